// File: rtl/mod_exp_if.sv
// ---------------------------------------------------------------------------
// mod_exp_if
//   Job/result bundle for the mod_exp modular exponentiation engine.
//
//   Signals
//     start_n   active-low start request (driven by the requester)
//     base      message / ciphertext operand
//     exponent  exponent (public e or private D)
//     modulus   modulus N
//     result    base^exponent mod modulus, valid while ready_n is low
//     ready_n   active-low done flag
//     busy      high while a job is being computed
//
//   Modports
//     master    requester side (drives start_n and operands)
//     slave     engine side (drives result, ready_n, busy)
// ---------------------------------------------------------------------------
interface mod_exp_if #(
  parameter int WIDTH = 64
);
  logic             start_n;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             ready_n;
  logic             busy;

  modport master (
    output start_n, base, exponent, modulus,
    input  result, ready_n, busy
  );

  modport slave (
    input  start_n, base, exponent, modulus,
    output result, ready_n, busy
  );
endinterface

// File: rtl/mod_exp.sv
// ---------------------------------------------------------------------------
// mod_exp
//   Modular exponentiation engine: result = base^exponent mod modulus.
//   Used as the RSA encrypt/decrypt stage (public e or private D, N = p*q).
//
//   Algorithm: right-to-left square-and-multiply. Two bit-serial interleaved
//   modular multipliers run side by side, one producing r*b mod n and the
//   other b*b mod n, each taking WIDTH cycles (multiplier bits MSB first).
//
//   Ports
//     clk     system clock, everything on the rising edge
//     rst_n   synchronous active-low reset; aborts any job in flight
//     bus     mod_exp_if.slave: start_n, base, exponent, modulus in;
//             result, ready_n, busy out
//
//   Parameters
//     WIDTH   operand/result width in bits (>= 4)
//
//   Build option
//     MOD_EXP_CONST_TIME_EN  when defined, every job with modulus >= 2 runs
//       exactly WIDTH square-and-multiply steps regardless of the exponent,
//       so latency does not leak the exponent bit-length. Results match the
//       default build, which stops as soon as the remaining exponent is zero.
//
//   Timing (A = edge that accepts start_n low)
//     modulus < 2   : ready_n falls at A + 1, result 0
//     otherwise     : ready_n falls at A + 1 + WIDTH*(1+k), k = bit-length of
//                     the exponent (WIDTH in the constant-time build)
// ---------------------------------------------------------------------------
module mod_exp #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  mod_exp_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    STEP,
    DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Captured job and working registers
  logic [WIDTH-1:0]      mod_reg;
  logic [WIDTH-1:0]      exp_reg;
  logic [WIDTH-1:0]      r_reg;
  logic [WIDTH-1:0]      b_reg;
  logic [WIDTH-1:0]      m_sh_reg;   // multiplier bits, consumed from the MSB
  logic [WIDTH-1:0]      result_reg;
  logic                  ready_n_reg;
  logic [CW-1:0]         cnt_reg;

  // Multiplier unit 0 computes r*m mod n, unit 1 computes b*m mod n
  // (during REDUCE unit 1 computes 1*base mod n).
  logic [1:0][WIDTH-1:0] acc_reg;
  logic [1:0][WIDTH-1:0] acc_next;
  logic [1:0][WIDTH-1:0] a_op;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam int SW = $clog2(WIDTH + 1);
  logic [SW-1:0]         steps_reg;  // squarings still to perform
`endif

  // Control strobes from the FSM
  logic accept;
  logic small_mod;
  logic run;
  logic last;
  logic finish;
  logic term;
  logic busy;
  logic cnt_last;
  logic m_bit;

  // -------------------------------------------------------------------------
  // One interleaved mod-multiply iteration:
  //   t = 2*acc + (m_bit ? a : 0), then subtract n up to twice.
  // With acc < n and a < n, t < 3n, so two conditional subtractions restore
  // acc < n. The intermediate needs WIDTH+2 bits; the stored acc fits WIDTH.
  // -------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] mulmod_step(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] a,
    input logic             mb,
    input logic [WIDTH-1:0] n
  );
    logic [AW-1:0] t;
    logic [AW-1:0] n_ext;
    n_ext = {2'b00, n};
    t = {1'b0, acc, 1'b0} + (mb ? {2'b00, a} : {AW{1'b0}});
    if (t >= n_ext) t = t - n_ext;
    if (t >= n_ext) t = t - n_ext;
    return t[WIDTH-1:0];
  endfunction

  assign small_mod = (bus.modulus < WIDTH'(2));
  assign cnt_last  = (cnt_reg == CW'(WIDTH - 1));
  assign m_bit     = m_sh_reg[WIDTH-1];

`ifdef MOD_EXP_CONST_TIME_EN
  assign term = (steps_reg == '0);
`else
  assign term = (exp_reg == '0);
`endif

  // Multiplicands: unit 0 always multiplies r; unit 1 multiplies 1 while
  // reducing the base, otherwise the current b (squaring).
  assign a_op[0] = r_reg;
  assign a_op[1] = (state_reg == REDUCE) ? WIDTH'(1) : b_reg;

  // Both units share the multiplier bit stream (old b, or base in REDUCE).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mul
      assign acc_next[gi] = mulmod_step(acc_reg[gi], a_op[gi], m_bit, mod_reg);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes.
  // A modulus below 2 is routed through one STEP boundary with r=0 and no
  // exponent left, so it finishes on the edge after acceptance with result 0.
  // The termination test happens at a step boundary (cnt_reg==0) and costs
  // one edge only when it ends the job; otherwise that edge already runs the
  // first multiply iteration of the next step.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    run        = 1'b0;
    last       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (!bus.start_n) begin
          accept     = 1'b1;
          state_next = small_mod ? STEP : REDUCE;
        end
      end
      REDUCE: begin
        busy = 1'b1;
        run  = 1'b1;
        if (cnt_last) begin
          last       = 1'b1;
          state_next = STEP;
        end
      end
      STEP: begin
        busy = 1'b1;
        if ((cnt_reg == '0) && term) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          run  = 1'b1;
          last = cnt_last;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_reg     <= '0;
      exp_reg     <= '0;
      r_reg       <= '0;
      b_reg       <= '0;
      m_sh_reg    <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      ready_n_reg <= 1'b1;
`ifdef MOD_EXP_CONST_TIME_EN
      steps_reg   <= '0;
`endif
    end else if (accept) begin
      mod_reg     <= bus.modulus;
      exp_reg     <= small_mod ? '0 : bus.exponent;
      r_reg       <= small_mod ? '0 : WIDTH'(1);
      b_reg       <= '0;
      m_sh_reg    <= bus.base;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ready_n_reg <= 1'b1;
`ifdef MOD_EXP_CONST_TIME_EN
      steps_reg   <= small_mod ? '0 : SW'(WIDTH);
`endif
    end else if (run) begin
      if (last) begin
        // Step boundary: commit products, restart both accumulators and
        // reload the multiplier stream with the new b.
        acc_reg  <= '0;
        cnt_reg  <= '0;
        b_reg    <= acc_next[1];
        m_sh_reg <= acc_next[1];
        if (state_reg == STEP) begin
          if (exp_reg[0]) begin
            r_reg <= acc_next[0];
          end
          exp_reg <= exp_reg >> 1;
`ifdef MOD_EXP_CONST_TIME_EN
          steps_reg <= steps_reg - SW'(1);
`endif
        end
      end else begin
        acc_reg  <= acc_next;
        cnt_reg  <= cnt_reg + CW'(1);
        m_sh_reg <= m_sh_reg << 1;
      end
    end else if (finish) begin
      result_reg  <= r_reg;
      ready_n_reg <= 1'b0;
    end
  end

  assign bus.result  = result_reg;
  assign bus.ready_n = ready_n_reg;
  assign bus.busy    = busy;

endmodule
